// File: rtl/shift_op_queue_pkg.sv
// Shared definitions for the shift request queue: select encodings and the
// request record stored in each FIFO entry (the tag is stored alongside it).
package shift_queue_pkg;

    localparam logic [1:0] SEL_SLL = 2'b00;
    localparam logic [1:0] SEL_SRL = 2'b01;
    localparam logic [1:0] SEL_SRA = 2'b11;
    localparam logic [1:0] SEL_RSV = 2'b10;

    typedef struct packed {
        logic [31:0] A;
        logic [4:0]  B;
        logic [1:0]  Select;
    } shift_req_t;

endpackage

// File: rtl/shift_op_queue_shift.sv
// SHIFT: combinational 32-bit barrel shifter.
// Select bit 0 picks the right-shift direction, bit 1 picks arithmetic fill.
// Reserved 2'b10 therefore behaves as a left shift.
module shift
    import shift_queue_pkg::*;
(
    input  logic [31:0] A,
    input  logic [4:0]  B,
    input  logic [1:0]  Select,
    output logic [31:0] Y
);

    // Shift direction and fill chosen by Select.
    always_comb begin
        Y = A << B;
        case (Select)
            SEL_SRL: Y = A >> B;
            SEL_SRA: Y = $signed(A) >>> B;
            default: Y = A << B;
        endcase
    end

endmodule

// File: rtl/shift_op_queue.sv
// shift_op_queue: DEPTH-entry request FIFO feeding a SHIFT instance, with a
// registered output stage on a valid/ready handshake.
// Optional macro SHIFT_QUEUE_SELECT_CHK_EN: flag reserved-select ops with
// Out_Err and a zero result instead of forwarding them to SHIFT.
module shift_op_queue
    import shift_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         In_Valid,
    output logic                         In_Ready,
    input  logic [31:0]                  In_A,
    input  logic [4:0]                   In_B,
    input  logic [1:0]                   In_Select,
    input  logic [TAG_W-1:0]             In_Tag,
    output logic                         Out_Valid,
    input  logic                         Out_Ready,
    output logic [31:0]                  Result,
    output logic [TAG_W-1:0]             Out_Tag,
    output logic                         Out_Err,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Storage is read asynchronously at the head so a pushed op can reach
    // the output register one edge later; it is never reset.
    shift_req_t       req_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             out_valid_reg;
    logic [31:0]      result_reg;
    logic [TAG_W-1:0] out_tag_reg;

    logic             push;
    logic             pop;
    shift_req_t       head;
    logic [31:0]      shift_y;
    logic [31:0]      result_next;

    // Full blocks input even when a pop happens this cycle, so In_Ready
    // depends on registered state only.
    assign In_Ready = (count_reg != CNT_W'(DEPTH));
    assign push     = In_Valid && In_Ready;
    assign pop      = (count_reg != '0) && (!out_valid_reg || Out_Ready);
    assign head     = req_mem[rd_ptr_reg];

    shift u_shift (
        .A      (head.A),
        .B      (head.B),
        .Select (head.Select),
        .Y      (shift_y)
    );

`ifdef SHIFT_QUEUE_SELECT_CHK_EN
    logic head_rsv;
    logic err_reg;

    assign head_rsv    = (head.Select == SEL_RSV);
    assign result_next = head_rsv ? 32'h0 : shift_y;
    assign Out_Err     = err_reg;

    // Error flag travels with its result through the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (pop) begin
            err_reg <= head_rsv;
        end
    end
`else
    assign result_next = shift_y;
    assign Out_Err     = 1'b0;
`endif

    // FIFO entry write on an accepted request.
    always_ff @(posedge clk) begin
        if (push) begin
            req_mem[wr_ptr_reg] <= '{A: In_A, B: In_B, Select: In_Select};
            tag_mem[wr_ptr_reg] <= In_Tag;
        end
    end

    // Pointers, occupancy and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            out_tag_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (pop) begin
                out_valid_reg <= 1'b1;
                result_reg    <= result_next;
                out_tag_reg   <= tag_mem[rd_ptr_reg];
            end else if (Out_Ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign Out_Valid = out_valid_reg;
    assign Result    = result_reg;
    assign Out_Tag   = out_tag_reg;
    assign Count     = count_reg;
    assign Busy      = (count_reg != '0) || out_valid_reg;

endmodule

// File: tb/tb_shift_op_queue.sv
// Directed self-checking bench for shift_op_queue (DEPTH=4, TAG_W=4).
// Honors SHIFT_QUEUE_SELECT_CHK_EN for the reserved-select expectations.
module tb_shift_op_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_b;
    logic [1:0]  in_select;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  out_tag;
    logic        out_err;
    logic [2:0]  count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    shift_op_queue #(.DEPTH(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .In_Valid  (in_valid),
        .In_Ready  (in_ready),
        .In_A      (in_a),
        .In_B      (in_b),
        .In_Select (in_select),
        .In_Tag    (in_tag),
        .Out_Valid (out_valid),
        .Out_Ready (out_ready),
        .Result    (result),
        .Out_Tag   (out_tag),
        .Out_Err   (out_err),
        .Count     (count),
        .Busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; drive and sample 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [4:0] b,
                           input logic [1:0] sel, input logic [3:0] tag);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_select = sel;
        in_tag    = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_select = '0; in_tag = '0;
        step(); step();
        rst = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", out_err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        $display("reset: count=%0d out_valid=%b in_ready=%b", count, out_valid, in_ready);
    endtask

    task automatic test_sll();
        out_ready = 1'b1;
        set_req(32'h0000_0001, 5'd4, 2'b00, 4'd5);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sll_early_valid got=%b want=0", out_valid); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL sll_count got=%0d want=1", count); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sll_valid got=%b want=1", out_valid); end
        total++; if (result !== 32'h0000_0010) begin bad++; $display("FAIL sll_result got=%h want=00000010", result); end
        total++; if (out_tag !== 4'd5) begin bad++; $display("FAIL sll_tag got=%0d want=5", out_tag); end
        $display("sll: result=%h tag=%0d", result, out_tag);
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sll_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_sra_srl();
        logic [4:0]  tb_b   [4] = '{5'd31, 5'd31, 5'd0, 5'd0};
        logic [1:0]  tb_sel [4] = '{2'b11, 2'b01, 2'b11, 2'b01};
        logic [31:0] tb_exp [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(32'h8000_0000, tb_b[i], tb_sel[i], 4'(i + 8));
            step();
            in_valid = 1'b0;
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL shr_valid[%0d] got=%b want=1", i, out_valid); end
            total++; if (result !== tb_exp[i]) begin bad++; $display("FAIL shr_result[%0d] got=%h want=%h", i, result, tb_exp[i]); end
            total++; if (out_tag !== 4'(i + 8)) begin bad++; $display("FAIL shr_tag[%0d] got=%0d want=%0d", i, out_tag, i + 8); end
            total++; if (out_err !== 1'b0) begin bad++; $display("FAIL shr_err[%0d] got=%b want=0", i, out_err); end
            $display("shr[%0d]: sel=%b b=%0d result=%h", i, tb_sel[i], tb_b[i], result);
            step();
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_req(32'hA0 + 32'(i), 5'd0, 2'b00, 4'(i));
            if (in_ready === 1'b1) accepted++;
            step();
        end
        in_valid = 1'b0;
        total++; if (accepted != 5) begin bad++; $display("FAIL bp_accepted got=%0d want=5", accepted); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d want=4", count); end
        step(); step();
        total++; if (result !== 32'hA0) begin bad++; $display("FAIL bp_hold_result got=%h want=000000a0", result); end
        total++; if (out_tag !== 4'd0) begin bad++; $display("FAIL bp_hold_tag got=%0d want=0", out_tag); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++; if (out_valid !== 1'b1 || out_tag !== 4'(k)) begin
                bad++; $display("FAIL bp_drain[%0d] got valid=%b tag=%0d want valid=1 tag=%0d", k, out_valid, out_tag, k);
            end
            total++; if (result !== 32'hA0 + 32'(k)) begin bad++; $display("FAIL bp_drain_result[%0d] got=%h want=%h", k, result, 32'hA0 + 32'(k)); end
            $display("bp drain: tag=%0d result=%h", out_tag, result);
            step();
        end
        total++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            bad++; $display("FAIL bp_empty got valid=%b count=%0d want valid=0 count=0", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            if (c < 16) set_req(32'h1, 5'(c), 2'b00, 4'(c));
            else in_valid = 1'b0;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", c, in_ready); end
            step();
            if (c >= 1) begin
                total++; if (out_valid !== 1'b1 || out_tag !== 4'(c - 1)) begin
                    bad++; $display("FAIL b2b_out[%0d] got valid=%b tag=%0d want valid=1 tag=%0d", c, out_valid, out_tag, c - 1);
                end
                total++; if (result !== (32'h1 << (c - 1))) begin
                    bad++; $display("FAIL b2b_result[%0d] got=%h want=%h", c, result, 32'h1 << (c - 1));
                end
                $display("b2b: tag=%0d result=%h count=%0d", out_tag, result, count);
            end
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_count got=%0d want=0", count); end
        step();
        // Push and pop together while three entries wait in the FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(32'h100 + 32'(i), 5'd0, 2'b00, 4'(i));
            step();
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL pp_pre_count got=%0d want=3", count); end
        out_ready = 1'b1;
        set_req(32'h104, 5'd0, 2'b00, 4'd4);
        step();
        in_valid = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL pp_count got=%0d want=3", count); end
        total++; if (out_tag !== 4'd1) begin bad++; $display("FAIL pp_tag got=%0d want=1", out_tag); end
        $display("push+pop at count 3: count=%0d tag=%0d", count, out_tag);
        for (int k = 2; k < 5; k++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_tag !== 4'(k)) begin
                bad++; $display("FAIL pp_drain[%0d] got valid=%b tag=%0d", k, out_valid, out_tag);
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(32'h55 + 32'(i), 5'd1, 2'b00, 4'(i + 3));
            step();
        end
        in_valid = 1'b0;
        total++; if (count !== 3'd3 || out_valid !== 1'b1) begin
            bad++; $display("FAIL mid_pre got count=%0d valid=%b want count=3 valid=1", count, out_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL mid_result got=%h want=0", result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
        $display("mid reset: count=%0d valid=%b result=%h", count, out_valid, result);
        out_ready = 1'b1;
        set_req(32'h3, 5'd2, 2'b00, 4'd14);
        step();
        in_valid = 1'b0;
        step();
        total++; if (out_tag !== 4'd14 || result !== 32'hC) begin
            bad++; $display("FAIL mid_after got tag=%0d result=%h want tag=14 result=0000000c", out_tag, result);
        end
        step();
    endtask

    task automatic test_reserved();
        logic [31:0] exp_res;
        logic        exp_err;
`ifdef SHIFT_QUEUE_SELECT_CHK_EN
        exp_res = 32'h0;
        exp_err = 1'b1;
`else
        exp_res = 32'h2345_6780;
        exp_err = 1'b0;
`endif
        out_ready = 1'b1;
        set_req(32'h1234_5678, 5'd4, 2'b10, 4'd9);
        step();
        in_valid = 1'b0;
        step();
        total++; if (out_err !== exp_err) begin bad++; $display("FAIL rsv_err got=%b want=%b", out_err, exp_err); end
        total++; if (result !== exp_res) begin bad++; $display("FAIL rsv_result got=%h want=%h", result, exp_res); end
        total++; if (out_tag !== 4'd9 || out_valid !== 1'b1) begin
            bad++; $display("FAIL rsv_tag got tag=%0d valid=%b want tag=9 valid=1", out_tag, out_valid);
        end
        $display("reserved: err=%b result=%h tag=%0d", out_err, result, out_tag);
        step();
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
